// File: rtl/div_59x35.sv
// Sequential signed restoring divider: 59-bit dividend by 35-bit divisor,
// one quotient bit per clock, saturated 24-bit quotient and 35-bit remainder.
module div_59x35 #(
  parameter int DIVIDEND_W = 59,
  parameter int DIVISOR_W  = 35,
  parameter int QUOT_W     = 24
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic signed [DIVIDEND_W-1:0] a,
  input  logic signed [DIVISOR_W-1:0]  b,
  output logic                         busy,
  output logic                         done,
  output logic signed [QUOT_W-1:0]     q,
  output logic signed [DIVISOR_W-1:0]  r,
  output logic                         ovf,
  output logic                         dz
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [DIVIDEND_W-1:0] POS_LIM = DIVIDEND_W'((64'd1 << (QUOT_W - 1)) - 64'd1);
  localparam logic [DIVIDEND_W-1:0] NEG_LIM = DIVIDEND_W'(64'd1 << (QUOT_W - 1));
  localparam logic [QUOT_W-1:0]     Q_MAX   = {1'b0, {(QUOT_W-1){1'b1}}};
  localparam logic [QUOT_W-1:0]     Q_MIN   = {1'b1, {(QUOT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_bmag;
  logic [DIVISOR_W-1:0]  r_rem;
  logic                  r_sa, r_sb, r_bz;
  logic                  r_done, r_ovf, r_dz;
  logic [QUOT_W-1:0]     r_q;
  logic [DIVISOR_W-1:0]  r_r;

  logic [DIVIDEND_W-1:0] w_amag;
  logic [DIVISOR_W-1:0]  w_bmag;
  logic [DIVISOR_W:0]    w_rem_sh;
  logic [DIVISOR_W-1:0]  w_diff;
  logic                  w_ge;
  logic                  w_neg;

  function automatic logic quot_ovf(input logic [DIVIDEND_W-1:0] mag, input logic neg);
    return neg ? (mag > NEG_LIM) : (mag > POS_LIM);
  endfunction

  function automatic logic [QUOT_W-1:0] sat_quot(input logic [DIVIDEND_W-1:0] mag,
                                                 input logic neg);
    logic [QUOT_W-1:0] m;
    m = mag[QUOT_W-1:0];
    if (quot_ovf(mag, neg)) return neg ? Q_MIN : Q_MAX;
    return neg ? (~m + QUOT_W'(1)) : m;
  endfunction

  // Magnitudes are unsigned so that |-2^(W-1)| stays representable.
  assign w_amag = a[DIVIDEND_W-1] ? ($unsigned(~a) + DIVIDEND_W'(1)) : $unsigned(a);
  assign w_bmag = b[DIVISOR_W-1]  ? ($unsigned(~b) + DIVISOR_W'(1))  : $unsigned(b);

  assign w_rem_sh = {r_rem, r_dvd[DIVIDEND_W-1]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_bmag});
  assign w_diff   = w_rem_sh[DIVISOR_W-1:0] - r_bmag;
  assign w_neg    = r_sa ^ r_sb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (r_cnt == '0) w_state_nxt = FIX;
      FIX:     w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_dvd  <= '0;
      r_quo  <= '0;
      r_bmag <= '0;
      r_rem  <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_bz   <= 1'b0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
      r_dz   <= 1'b0;
      r_q    <= '0;
      r_r    <= '0;
    end else begin
      r_done <= (r_state == FIX);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_dvd  <= w_amag;
            r_quo  <= '0;
            r_rem  <= '0;
            r_bmag <= w_bmag;
            r_sa   <= a[DIVIDEND_W-1];
            r_sb   <= b[DIVISOR_W-1];
            r_bz   <= (b == '0);
            r_cnt  <= CNT_W'(DIVIDEND_W - 1);
          end
        end
        RUN: begin
          // One restoring step: shift in the next dividend bit, subtract if it fits.
          r_dvd <= r_dvd << 1;
          r_rem <= w_ge ? w_diff : w_rem_sh[DIVISOR_W-1:0];
          r_quo <= {r_quo[DIVIDEND_W-2:0], w_ge};
          r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          if (r_bz) begin
            r_q   <= r_sa ? Q_MIN : Q_MAX;
            r_r   <= '0;
            r_ovf <= 1'b0;
            r_dz  <= 1'b1;
          end else begin
            r_q   <= sat_quot(r_quo, w_neg);
            r_r   <= r_sa ? (~r_rem + DIVISOR_W'(1)) : r_rem;
            r_ovf <= quot_ovf(r_quo, w_neg);
            r_dz  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = r_done;
  assign q    = $signed(r_q);
  assign r    = $signed(r_r);
  assign ovf  = r_ovf;
  assign dz   = r_dz;

endmodule

// File: tb/tb_div_59x35.sv
// Randomised and directed bench for div_59x35 with a queue-based scoreboard
// and an arithmetic reference model.
module tb_div_59x35;

  logic                clk   = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic signed [58:0]  a     = '0;
  logic signed [34:0]  b     = '0;
  logic                busy, done, ovf, dz;
  logic signed [23:0]  q;
  logic signed [34:0]  r;

  div_59x35 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .q(q), .r(r), .ovf(ovf), .dz(dz)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint      a;
    longint      b;
    longint      q;
    longint      r;
    bit          ovf;
    bit          dz;
    int unsigned acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_tot++;
    $display("FAIL %s", nm);
  endtask

  // Reference: exact integer division, truncating toward zero, then saturate.
  function automatic exp_t model(input longint la, input longint lb);
    exp_t   e;
    longint qt;
    e.a = la; e.b = lb; e.ovf = 0; e.dz = 0; e.acc = 0;
    if (lb == 0) begin
      e.dz = 1;
      e.r  = 0;
      e.q  = (la < 0) ? -64'sd8388608 : 64'sd8388607;
    end else begin
      qt  = la / lb;
      e.r = la % lb;
      if (qt > 64'sd8388607) begin
        e.q = 64'sd8388607; e.ovf = 1;
      end else if (qt < -64'sd8388608) begin
        e.q = -64'sd8388608; e.ovf = 1;
      end else begin
        e.q = qt;
      end
    end
    return e;
  endfunction

  task automatic issue(input longint la, input longint lb);
    exp_t e;
    e = model(la, lb);
    a = la[58:0];
    b = lb[34:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_q"}, q, 0);
    chk({tag, "_r"}, r, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_dz"}, dz, 0);
  endtask

  // Monitor: every done pulse is matched against the oldest expectation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          e = sb.pop_front();
          chk("q", q, e.q);
          chk("r", r, e.r);
          chk("ovf", ovf, e.ovf);
          chk("dz", dz, e.dz);
          chk("latency", longint'(cyc - e.acc + 1), 61);
          if (!ovf && !dz)
            chk("identity", longint'(q) * e.b + longint'(r), e.a);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  longint da[13];
  longint db[13];

  initial begin : stim
    longint x, y;
    int     nd;

    da[0]  = 64'sd7937560975;       db[0]  = 64'sd121375;
    da[1]  = -64'sd7937560975;      db[1]  = 64'sd121375;
    da[2]  = 64'sd7937560975;       db[2]  = -64'sd121375;
    da[3]  = 64'sd1 <<< 53;         db[3]  = 64'sd1 <<< 31;
    da[4]  = -(64'sd1 <<< 53);      db[4]  = -(64'sd1 <<< 31);
    da[5]  = 64'sd1 <<< 57;         db[5]  = 64'sd1;
    da[6]  = -(64'sd1 <<< 58);      db[6]  = 64'sd1;
    da[7]  = -(64'sd1 <<< 23);      db[7]  = 64'sd1;
    da[8]  = 64'sd5;                db[8]  = 64'sd0;
    da[9]  = -64'sd5;               db[9]  = 64'sd0;
    da[10] = -(64'sd1 <<< 58);      db[10] = -(64'sd1 <<< 34);
    da[11] = -64'sd1;               db[11] = -(64'sd1 <<< 34);
    da[12] = (64'sd1 <<< 58) - 1;   db[12] = (64'sd1 <<< 34) - 1;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed corners; each issue lands in the previous done cycle.
    for (int i = 0; i < 13; i++) begin
      issue(da[i], db[i]);
      wait_done();
    end

    // A start while busy must not disturb the running division.
    issue(64'sd1000000007, 64'sd977);
    repeat (10) @(posedge clk);
    #1;
    chk("busy_mid_run", busy, 1);
    a = 59'sd12345; b = 35'sd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 40; i++) begin
      x = longint'({$urandom(), $urandom()}) >>> (5 + $urandom_range(0, 55));
      y = longint'({$urandom(), $urandom()}) >>> (29 + $urandom_range(0, 33));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
      #1;
      issue(x, y);
      wait_done();
    end

    // Reset in the middle of a division abandons it without a done.
    issue(64'sd123456789012345, 64'sd4321);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("midrun_reset");
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    nd = 0;
    repeat (70) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk("no_done_after_reset", nd, 0);

    issue(-64'sd987654321987, 64'sd55555);
    wait_done();

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
